// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity transmitter: FSM encoding and the
// width of the ones counter.
package serial_parity_pkg;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] SHIFT_ENC = 2'd1;
    localparam logic [1:0] PAR_ENC   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        SHIFT = SHIFT_ENC,
        PAR   = PAR_ENC
    } state_t;

    // Bits needed to hold a count of 0..width ones.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/parity_shift_reg.sv
// Loadable shift register with selectable direction. It exposes the bit that
// will be at the serial tap after this edge and the matching running ones count.
module parity_shift_reg
    import serial_parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter int CW        = count_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             tap_next,
    output logic [CW-1:0]    count_next
);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [CW-1:0]    count;

    // The tap always reads the head of the register, so the count includes the
    // head bit as soon as it is presented.
    always_comb begin
        sreg_next = sreg;
        if (load) begin
            sreg_next = data_in;
        end else if (shift) begin
            sreg_next = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
        end

        tap_next = LSB_FIRST ? sreg_next[0] : sreg_next[WIDTH-1];

        count_next = count;
        if (load) begin
            count_next = CW'(tap_next);
        end else if (shift) begin
            count_next = count + CW'(tap_next);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sreg  <= '0;
            count <= '0;
        end else begin
            sreg  <= sreg_next;
            count <= count_next;
        end
    end

endmodule

// File: rtl/serial_parity_tx.sv
// Parallel-to-serial transmitter with ones count and even/odd parity; the
// parity bit can optionally trail the data bits on the serial line.
//
// Handshake: a word is accepted on a rising edge where load=1 and ready=1;
// load at any other edge is ignored. serial_valid qualifies serial_out.
module serial_parity_tx
    import serial_parity_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter bit ODD_PARITY    = 1'b0,
    parameter bit LSB_FIRST     = 1'b0,
    parameter bit APPEND_PARITY = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          load,
    input  logic [WIDTH-1:0]              data_in,
    output logic                          ready,
    output logic                          busy,
    output logic                          serial_out,
    output logic                          serial_valid,
    output logic [count_width(WIDTH)-1:0] ones_count,
    output logic                          parity,
    output logic                          done,
    output state_t                        fsm_state
);

    localparam int CW = count_width(WIDTH);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST     = BW'(WIDTH - 1);
    localparam logic [BW-1:0] PRE_LAST = BW'(WIDTH - 2);

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_cnt_next;
    logic          serial_out_next;
    logic          serial_valid_next;
    logic          done_next;
    logic [CW-1:0] ones_count_next;
    logic          parity_next;
    logic          sr_load;
    logic          sr_shift;
    logic          tap_next;
    logic [CW-1:0] count_next;
    logic          parity_bit;

    parity_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST),
        .CW        (CW)
    ) u_shift (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (sr_load),
        .shift      (sr_shift),
        .data_in    (data_in),
        .tap_next   (tap_next),
        .count_next (count_next)
    );

    assign parity_bit = count_next[0] ^ ODD_PARITY;

    always_comb begin
        state_next        = state;
        bit_cnt_next      = bit_cnt;
        serial_out_next   = 1'b0;
        serial_valid_next = 1'b0;
        done_next         = 1'b0;
        ones_count_next   = ones_count;
        parity_next       = parity;
        sr_load           = 1'b0;
        sr_shift          = 1'b0;

        case (state)
            IDLE: begin
                if (load) begin
                    sr_load           = 1'b1;
                    state_next        = SHIFT;
                    bit_cnt_next      = '0;
                    serial_out_next   = tap_next;
                    serial_valid_next = 1'b1;
                    ones_count_next   = '0;
                    parity_next       = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST) begin
                    // Last data bit is on the line now; the count is final.
                    if (APPEND_PARITY) begin
                        state_next        = PAR;
                        serial_out_next   = parity_bit;
                        serial_valid_next = 1'b1;
                        done_next         = 1'b1;
                        ones_count_next   = count_next;
                        parity_next       = parity_bit;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    sr_shift          = 1'b1;
                    bit_cnt_next      = bit_cnt + BW'(1);
                    serial_out_next   = tap_next;
                    serial_valid_next = 1'b1;
                    // Without a parity bit, the edge presenting the final data
                    // bit is the one that completes the word.
                    if (!APPEND_PARITY && (bit_cnt == PRE_LAST)) begin
                        done_next       = 1'b1;
                        ones_count_next = count_next;
                        parity_next     = parity_bit;
                    end
                end
            end
            PAR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            done         <= 1'b0;
            ones_count   <= '0;
            parity       <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            serial_out   <= serial_out_next;
            serial_valid <= serial_valid_next;
            done         <= done_next;
            ones_count   <= ones_count_next;
            parity       <= parity_next;
        end
    end

    assign ready     = (state == IDLE);
    assign busy      = (state == SHIFT) || (state == PAR);
    assign fsm_state = state;

endmodule

// File: tb/tb_serial_parity_tx.sv
// Bench for serial_parity_tx: four parameter variants checked against a
// bit-stream model built from the word with plain arithmetic.
module tb_serial_parity_tx;
    import serial_parity_pkg::*;

    logic clk;
    logic rst_n;

    logic        ld   [4];
    logic [11:0] din  [4];
    logic        rdy  [4];
    logic        bsy  [4];
    logic        so   [4];
    logic        sv   [4];
    logic [3:0]  oc   [4];
    logic        par  [4];
    logic        dn   [4];
    state_t      st   [4];

    int cfg_w   [4] = '{8, 8, 8, 12};
    int cfg_odd [4] = '{0, 1, 0, 0};
    int cfg_lsb [4] = '{0, 0, 1, 0};
    int cfg_app [4] = '{1, 1, 0, 1};

    int n_cmp = 0;
    int n_bad = 0;

    serial_parity_tx #(.WIDTH(8), .ODD_PARITY(1'b0), .LSB_FIRST(1'b0), .APPEND_PARITY(1'b1)) u_dut0 (
        .clock(clk), .reset_n(rst_n), .load(ld[0]), .data_in(din[0][7:0]), .ready(rdy[0]),
        .busy(bsy[0]), .serial_out(so[0]), .serial_valid(sv[0]), .ones_count(oc[0]),
        .parity(par[0]), .done(dn[0]), .fsm_state(st[0]));

    serial_parity_tx #(.WIDTH(8), .ODD_PARITY(1'b1), .LSB_FIRST(1'b0), .APPEND_PARITY(1'b1)) u_dut1 (
        .clock(clk), .reset_n(rst_n), .load(ld[1]), .data_in(din[1][7:0]), .ready(rdy[1]),
        .busy(bsy[1]), .serial_out(so[1]), .serial_valid(sv[1]), .ones_count(oc[1]),
        .parity(par[1]), .done(dn[1]), .fsm_state(st[1]));

    serial_parity_tx #(.WIDTH(8), .ODD_PARITY(1'b0), .LSB_FIRST(1'b1), .APPEND_PARITY(1'b0)) u_dut2 (
        .clock(clk), .reset_n(rst_n), .load(ld[2]), .data_in(din[2][7:0]), .ready(rdy[2]),
        .busy(bsy[2]), .serial_out(so[2]), .serial_valid(sv[2]), .ones_count(oc[2]),
        .parity(par[2]), .done(dn[2]), .fsm_state(st[2]));

    serial_parity_tx #(.WIDTH(12), .ODD_PARITY(1'b0), .LSB_FIRST(1'b0), .APPEND_PARITY(1'b1)) u_dut3 (
        .clock(clk), .reset_n(rst_n), .load(ld[3]), .data_in(din[3]), .ready(rdy[3]),
        .busy(bsy[3]), .serial_out(so[3]), .serial_valid(sv[3]), .ones_count(oc[3]),
        .parity(par[3]), .done(dn[3]), .fsm_state(st[3]));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input int k, input string tag);
        check($sformatf("%s_d%0d_ready", tag, k), 32'(rdy[k]), 32'd1);
        check($sformatf("%s_d%0d_busy", tag, k), 32'(bsy[k]), 32'd0);
        check($sformatf("%s_d%0d_sout", tag, k), 32'(so[k]), 32'd0);
        check($sformatf("%s_d%0d_svalid", tag, k), 32'(sv[k]), 32'd0);
        check($sformatf("%s_d%0d_ones", tag, k), 32'(oc[k]), 32'd0);
        check($sformatf("%s_d%0d_parity", tag, k), 32'(par[k]), 32'd0);
        check($sformatf("%s_d%0d_done", tag, k), 32'(dn[k]), 32'd0);
        check($sformatf("%s_d%0d_state", tag, k), 32'(st[k]), 32'd0);
    endtask

    // Driver + scoreboard for one word. ign: cycle (1..len) at which a stray
    // load is raised for one cycle; rst_at: cycle at which reset_n is pulsed.
    task automatic transfer(input int k, input logic [11:0] word_raw, input int ign, input int rst_at);
        logic        exp_q[$];
        logic [11:0] word;
        int          width;
        int          len;
        int          ones;
        logic        pbit;
        logic        b;
        width = cfg_w[k];
        word  = 12'((32'(word_raw)) & ((32'd1 << width) - 1));
        ones  = $countones(word);
        pbit  = 1'((ones % 2) ^ cfg_odd[k]);
        for (int c = 1; c <= width; c++) begin
            int pos;
            pos = (cfg_lsb[k] != 0) ? (c - 1) : (width - c);
            exp_q.push_back(word[pos]);
        end
        if (cfg_app[k] != 0) exp_q.push_back(pbit);
        len = exp_q.size();

        @(negedge clk);
        check($sformatf("d%0d_ready_before_load", k), 32'(rdy[k]), 32'd1);
        din[k] = word;
        ld[k]  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            ld[k] = 1'b0;
            b = exp_q.pop_front();
            check($sformatf("d%0d_w%03h_c%0d_svalid", k, word, c), 32'(sv[k]), 32'd1);
            check($sformatf("d%0d_w%03h_c%0d_sout", k, word, c), 32'(so[k]), 32'(b));
            check($sformatf("d%0d_w%03h_c%0d_busy", k, word, c), 32'(bsy[k]), 32'd1);
            check($sformatf("d%0d_w%03h_c%0d_ready", k, word, c), 32'(rdy[k]), 32'd0);
            check($sformatf("d%0d_w%03h_c%0d_done", k, word, c), 32'(dn[k]), 32'(c == len));
            if (c == len) begin
                check($sformatf("d%0d_w%03h_ones", k, word), 32'(oc[k]), 32'(ones));
                check($sformatf("d%0d_w%03h_parity", k, word), 32'(par[k]), 32'(pbit));
            end else begin
                check($sformatf("d%0d_w%03h_c%0d_ones_cleared", k, word, c), 32'(oc[k]), 32'd0);
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_values(k, "midreset");
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check($sformatf("postreset_d%0d_i%0d_done", k, i), 32'(dn[k]), 32'd0);
                    check($sformatf("postreset_d%0d_i%0d_svalid", k, i), 32'(sv[k]), 32'd0);
                    check($sformatf("postreset_d%0d_i%0d_ready", k, i), 32'(rdy[k]), 32'd1);
                end
                return;
            end
            if (c == ign) begin
                ld[k]  = 1'b1;
                din[k] = 12'($urandom);
            end
        end
        @(negedge clk);
        ld[k] = 1'b0;
        check($sformatf("d%0d_w%03h_idle_ready", k, word), 32'(rdy[k]), 32'd1);
        check($sformatf("d%0d_w%03h_idle_busy", k, word), 32'(bsy[k]), 32'd0);
        check($sformatf("d%0d_w%03h_idle_svalid", k, word), 32'(sv[k]), 32'd0);
        check($sformatf("d%0d_w%03h_idle_sout", k, word), 32'(so[k]), 32'd0);
        check($sformatf("d%0d_w%03h_idle_done", k, word), 32'(dn[k]), 32'd0);
        check($sformatf("d%0d_w%03h_hold_ones", k, word), 32'(oc[k]), 32'(ones));
        check($sformatf("d%0d_w%03h_hold_parity", k, word), 32'(par[k]), 32'(pbit));
    endtask

    initial begin
        logic [7:0] w1;
        logic [7:0] w2;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ld[k]  = 1'b0;
            din[k] = '0;
        end
        #12;
        for (int k = 0; k < 4; k++) check_reset_values(k, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        transfer(0, 12'h0A5, -1, -1);
        transfer(1, 12'h007, -1, -1);
        transfer(2, 12'h001, -1, -1);
        transfer(0, 12'h000, 3, -1);
        transfer(0, 12'h0FF, 9, -1);
        transfer(3, 12'hFFF, -1, -1);
        transfer(0, 12'h0A5, -1, 4);
        transfer(0, 12'h03C, -1, -1);

        // load held high: one IDLE gap, then the next word starts
        w1 = 8'h5A;
        w2 = 8'h81;
        @(negedge clk);
        din[0] = 12'(w1);
        ld[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din[0] = 12'(w2);
        repeat (8) @(negedge clk);
        check("held_done_w1", 32'(dn[0]), 32'd1);
        check("held_ones_w1", 32'(oc[0]), 32'($countones(w1)));
        @(negedge clk);
        check("held_gap_ready", 32'(rdy[0]), 32'd1);
        check("held_gap_svalid", 32'(sv[0]), 32'd0);
        @(negedge clk);
        ld[0] = 1'b0;
        check("held_w2_svalid", 32'(sv[0]), 32'd1);
        check("held_w2_first_bit", 32'(so[0]), 32'(w2[7]));
        repeat (8) @(negedge clk);
        check("held_done_w2", 32'(dn[0]), 32'd1);
        check("held_ones_w2", 32'(oc[0]), 32'($countones(w2)));
        @(negedge clk);
        check("held_end_ready", 32'(rdy[0]), 32'd1);

        // Randomized words with stray loads at random cycles
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                transfer(k, 12'($urandom), int'($urandom_range(0, 13)), -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
